// File: rtl/cam_pattern_gen.sv
// Synthetic OV7670-style DVP source: pclk/vsync/href/RGB565 byte stream generated from sys_clk.
// Stands in for the camera sensor in front of the frame-buffer capture path.
module cam_pattern_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned H_BLANK   = 144,
  parameter int unsigned VS_LINES  = 3,
  parameter int unsigned VBP_LINES = 17,
  parameter int unsigned VFP_LINES = 10,
  parameter int unsigned PCLK_DIV  = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       pclk_cam,
  output logic       vsync_cam,
  output logic       href_cam,
  output logic [7:0] wdata_cam,
  output logic       frame_done
);

  localparam int unsigned LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned VS_DUR    = VS_LINES * LINE_LEN;
  localparam int unsigned VBP_DUR   = VBP_LINES * LINE_LEN;
  localparam int unsigned VFP_DUR   = VFP_LINES * LINE_LEN;
  localparam int unsigned ACT_DUR   = 2 * H_ACTIVE;
  localparam int unsigned MAX_LINES = (VS_LINES > VBP_LINES) ?
                                      ((VS_LINES > VFP_LINES) ? VS_LINES : VFP_LINES) :
                                      ((VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES);
  localparam int unsigned CW        = $clog2(MAX_LINES * LINE_LEN + 1);
  localparam int unsigned DW        = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
  localparam int unsigned PRE_DIV   = (PCLK_DIV > 1) ? PCLK_DIV - 2 : 0;
  localparam int unsigned XW        = ($clog2(H_ACTIVE) > 8) ? $clog2(H_ACTIVE) : 8;
  localparam int unsigned YW        = ($clog2(V_ACTIVE) > 4) ? $clog2(V_ACTIVE) : 4;
  localparam int unsigned BAR_W     = H_ACTIVE / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_HBLANK,
    S_VFP
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [YW-1:0]   r_y, w_y_nxt;
  logic [1:0]      r_pat, w_pat_nxt;
  logic [DW-1:0]   r_div;
  logic            r_pclk;
  logic            r_vsync;
  logic            r_href;
  logic [7:0]      r_data;
  logic            r_frame_done;

  logic            w_fall;
  logic            w_pre_fall;
  logic            w_vfp_last;
  logic [XW-1:0]   w_x;
  logic [XW-1:0]   w_bar;
  logic [2:0]      w_bar_idx;
  logic [15:0]     w_bar_rgb;
  logic [7:0]      w_g;
  logic [15:0]     w_rgb;
  logic [7:0]      w_data_nxt;

  // Byte-time boundary: the sys_clk edge on which pclk goes 1->0.
  assign w_fall     = r_pclk && (r_div == DW'(PCLK_DIV - 1));
  // One sys_clk ahead of w_fall, so frame_done lands on the last sys_clk of VFP.
  assign w_pre_fall = (PCLK_DIV == 1) ? !r_pclk : (r_pclk && (r_div == DW'(PRE_DIV)));
  assign w_vfp_last = (r_state == S_VFP) && (r_cnt == CW'(VFP_DUR - 1));

  always_ff @(posedge sys_clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_y_nxt     = r_y;
    w_pat_nxt   = r_pat;
    if (w_fall) begin
      w_cnt_nxt = r_cnt + CW'(1);
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (enable) begin
            w_state_nxt = S_VSYNC;
            w_pat_nxt   = pattern_sel;
          end
        end
        S_VSYNC: begin
          if (r_cnt == CW'(VS_DUR - 1)) begin
            w_state_nxt = S_VBP;
            w_cnt_nxt   = '0;
          end
        end
        S_VBP: begin
          if (r_cnt == CW'(VBP_DUR - 1)) begin
            w_state_nxt = S_ACTIVE;
            w_cnt_nxt   = '0;
            w_y_nxt     = '0;
          end
        end
        S_ACTIVE: begin
          if (r_cnt == CW'(ACT_DUR - 1)) begin
            w_state_nxt = S_HBLANK;
            w_cnt_nxt   = '0;
          end
        end
        S_HBLANK: begin
          if (r_cnt == CW'(H_BLANK - 1)) begin
            w_cnt_nxt = '0;
            if (r_y < YW'(V_ACTIVE - 1)) begin
              w_state_nxt = S_ACTIVE;
              w_y_nxt     = r_y + YW'(1);
            end else begin
              w_state_nxt = S_VFP;
            end
          end
        end
        S_VFP: begin
          if (r_cnt == CW'(VFP_DUR - 1)) begin
            w_cnt_nxt = '0;
            if (enable) begin
              w_state_nxt = S_VSYNC;
              w_pat_nxt   = pattern_sel;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Pixel byte for the byte-time about to start; x is the byte index halved.
  always_comb begin
    w_x       = XW'(w_cnt_nxt >> 1);
    w_bar     = w_x / XW'(BAR_W);
    w_bar_idx = (w_bar > XW'(7)) ? 3'd7 : w_bar[2:0];
    w_bar_rgb = 16'h0000;
    case (w_bar_idx)
      3'd0:    w_bar_rgb = 16'hFFFF;
      3'd1:    w_bar_rgb = 16'hFFE0;
      3'd2:    w_bar_rgb = 16'h07FF;
      3'd3:    w_bar_rgb = 16'h07E0;
      3'd4:    w_bar_rgb = 16'hF81F;
      3'd5:    w_bar_rgb = 16'hF800;
      3'd6:    w_bar_rgb = 16'h001F;
      default: w_bar_rgb = 16'h0000;
    endcase
    w_g   = w_x[7:0];
    w_rgb = 16'h001F;
    case (r_pat)
      2'd0:    w_rgb = w_bar_rgb;
      2'd1:    w_rgb = {w_g[7:3], w_g[7:2], w_g[7:3]};
      2'd2:    w_rgb = (w_x[3] ^ w_y_nxt[3]) ? 16'hFFFF : 16'h0000;
      default: w_rgb = 16'h001F;
    endcase
    w_data_nxt = 8'h00;
    if (w_state_nxt == S_ACTIVE) w_data_nxt = w_cnt_nxt[0] ? w_rgb[7:0] : w_rgb[15:8];
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_div        <= '0;
      r_pclk       <= 1'b0;
      r_cnt        <= '0;
      r_y          <= '0;
      r_pat        <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_data       <= 8'h00;
      r_frame_done <= 1'b0;
    end else begin
      if (r_div == DW'(PCLK_DIV - 1)) begin
        r_div  <= '0;
        r_pclk <= ~r_pclk;
      end else begin
        r_div  <= r_div + DW'(1);
      end
      r_cnt <= w_cnt_nxt;
      r_y   <= w_y_nxt;
      r_pat <= w_pat_nxt;
      if (w_fall) begin
        r_vsync <= (w_state_nxt == S_VSYNC);
        r_href  <= (w_state_nxt == S_ACTIVE);
        r_data  <= w_data_nxt;
      end
      r_frame_done <= w_pre_fall && w_vfp_last;
    end
  end

  assign pclk_cam   = r_pclk;
  assign vsync_cam  = r_vsync;
  assign href_cam   = r_href;
  assign wdata_cam  = r_data;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Bench for cam_pattern_gen: randomized frame patterns, scoreboard of expected pixel bytes
// and a monitor that checks DVP framing as a receiver sampling on rising pclk would see it.
module tb_cam_pattern_gen;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int HB = 4;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int PD = 2;
  localparam int L  = 2 * H + HB;
  localparam int FRAME_SYS = (VS + VB + V + VF) * L * 2 * PD;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       pclk_cam;
  logic       vsync_cam;
  logic       href_cam;
  logic [7:0] wdata_cam;
  logic       frame_done;

  always #5 sys_clk = ~sys_clk;

  cam_pattern_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .VS_LINES(VS),
    .VBP_LINES(VB), .VFP_LINES(VF), .PCLK_DIV(PD)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .pclk_cam   (pclk_cam),
    .vsync_cam  (vsync_cam),
    .href_cam   (href_cam),
    .wdata_cam  (wdata_cam),
    .frame_done (frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  int cyc = 0, vs_rises = 0, href_rises = 0, fd_count = 0, pclk_rises = 0;
  int act_samples = 0, viol = 0;
  int vs_cnt = 0, href_run = 0, lines = 0, vs_rise_cyc = 0, last_rise = 0;
  bit rise_valid = 0, after_rst = 0;
  logic p_pclk, p_vsync, p_href, p_fd;
  logic [7:0] p_data;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference pixel straight from the pattern definitions.
  function automatic logic [15:0] ref_pixel(input int x, input int y, input int pat);
    logic [15:0] bars [8];
    logic [7:0]  g;
    int          bar;
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (pat)
      0: begin
        bar = x / (H / 8);
        if (bar > 7) bar = 7;
        return bars[bar];
      end
      1: begin
        g = 8'(x);
        return {g[7:3], g[7:2], g[7:3]};
      end
      2: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return 16'h001F;
    endcase
  endfunction

  task automatic push_frame(input int pat);
    logic [15:0] w;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        w = ref_pixel(x, y, pat);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
      end
    end
  endtask

  function automatic int sel_count(input int which);
    case (which)
      0:       return vs_rises;
      1:       return href_rises;
      default: return fd_count;
    endcase
  endfunction

  task automatic wait_until(input string name, input int which, input int target, input int budget);
    int b;
    b = budget;
    while (sel_count(which) < target && b > 0) begin
      @(negedge sys_clk);
      b--;
    end
    if (sel_count(which) < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out, counter %0d, required %0d", name, sel_count(which), target);
    end
  endtask

  // Monitor: samples 1 time unit after each sys_clk edge.
  always @(posedge sys_clk) begin
    logic [7:0] e;
    #1;
    cyc++;
    if (rst) begin
      vs_cnt     = 0;
      href_run   = 0;
      lines      = 0;
      rise_valid = 0;
      after_rst  = 1;
    end else begin
      if ({vsync_cam, href_cam, wdata_cam} != {p_vsync, p_href, p_data} && !(p_pclk && !pclk_cam))
        viol++;
      if (frame_done && p_fd) viol++;
      if (vsync_cam && href_cam) viol++;
      if (vsync_cam || href_cam) act_samples++;
      if (after_rst && (vsync_cam || href_cam)) begin
        check("first_activity_is_vsync", int'({href_cam, vsync_cam}), 1);
        after_rst = 0;
      end
      if (vsync_cam && !p_vsync) begin
        vs_rises++;
        vs_rise_cyc = cyc;
        lines = 0;
      end
      if (href_cam && !p_href) href_rises++;
      if (frame_done) begin
        fd_count++;
        // frame_done occupies the final sys_clk of the frame that started with vsync
        check("frame_done_offset", cyc - vs_rise_cyc, FRAME_SYS - 1);
        check("lines_per_frame", lines, V);
      end
      if (pclk_cam && !p_pclk) begin
        pclk_rises++;
        if (rise_valid) check("pclk_period", cyc - last_rise, 2 * PD);
        last_rise  = cyc;
        rise_valid = 1;
        if (vsync_cam) vs_cnt++;
        else if (vs_cnt > 0) begin
          check("vsync_pclks", vs_cnt, VS * L);
          vs_cnt = 0;
        end
        if (href_cam) begin
          href_run++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pixel_byte: got 0x%0h, expected no byte (scoreboard empty)", wdata_cam);
          end else begin
            e = exp_q.pop_front();
            check("pixel_byte", int'(wdata_cam), int'(e));
          end
        end else if (href_run > 0) begin
          check("href_pclks", href_run, 2 * H);
          href_run = 0;
          lines++;
        end
      end
    end
    p_pclk  = pclk_cam;
    p_vsync = vsync_cam;
    p_href  = href_cam;
    p_data  = wdata_cam;
    p_fd    = frame_done;
  end

  initial begin
    int pats[5];
    int base, pat, act_mark;
    rst = 1'b1;
    enable = 1'b0;
    pattern_sel = 2'd0;
    repeat (10) @(negedge sys_clk);
    check("rst_pclk", int'(pclk_cam), 0);
    check("rst_vsync", int'(vsync_cam), 0);
    check("rst_href", int'(href_cam), 0);
    check("rst_wdata", int'(wdata_cam), 0);
    check("rst_frame_done", int'(frame_done), 0);
    rst = 1'b0;

    repeat (1000) @(negedge sys_clk);
    check("idle_activity", act_samples, 0);
    check("idle_wdata", int'(wdata_cam), 0);
    check("idle_pclk_running", int'(pclk_rises >= 249), 1);

    pats[0] = 0;
    pats[1] = 1;
    pats[2] = 2;
    pats[3] = int'($urandom_range(0, 3));
    pats[4] = int'($urandom_range(0, 2));
    pattern_sel = 2'(pats[0]);
    push_frame(pats[0]);
    enable = 1'b1;
    for (int f = 0; f < 5; f++) begin
      wait_until("vsync_start", 0, f + 1, 2 * FRAME_SYS);
      base = href_rises;
      wait_until("line2_start", 1, base + 3, FRAME_SYS);
      // The frame in flight keeps its pattern; the new selection applies to the next frame.
      if (f < 4) begin
        pattern_sel = 2'(pats[f + 1]);
        push_frame(pats[f + 1]);
      end else begin
        pattern_sel = 2'd3;
        enable = 1'b0;
      end
      wait_until("frame_done", 2, f + 1, FRAME_SYS);
    end
    act_mark = act_samples;
    repeat (2000) @(negedge sys_clk);
    check("stop_vsync_count", vs_rises, 5);
    check("stop_no_activity", act_samples, act_mark);
    check("stop_queue_drained", exp_q.size(), 0);

    pat = int'($urandom_range(0, 3));
    pattern_sel = 2'(pat);
    push_frame(pat);
    enable = 1'b1;
    wait_until("rst_frame_vsync", 0, 6, 2 * FRAME_SYS);
    base = href_rises;
    wait_until("rst_frame_line1", 1, base + 2, FRAME_SYS);
    repeat ($urandom_range(1, 12)) @(negedge sys_clk);
    check("pre_rst_href", int'(href_cam), 1);
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    check("midrst_pclk", int'(pclk_cam), 0);
    check("midrst_vsync", int'(vsync_cam), 0);
    check("midrst_href", int'(href_cam), 0);
    check("midrst_wdata", int'(wdata_cam), 0);
    check("midrst_frame_done", int'(frame_done), 0);
    exp_q.delete();
    @(negedge sys_clk);
    rst = 1'b0;
    pat = int'($urandom_range(0, 3));
    pattern_sel = 2'(pat);
    push_frame(pat);
    wait_until("restart_vsync", 0, 7, 2 * FRAME_SYS);
    base = href_rises;
    wait_until("restart_line2", 1, base + 3, FRAME_SYS);
    enable = 1'b0;
    wait_until("restart_frame_done", 2, 6, FRAME_SYS);
    repeat (1000) @(negedge sys_clk);
    check("final_queue_drained", exp_q.size(), 0);
    check("final_vsync_count", vs_rises, 7);
    check("final_frame_done_count", fd_count, 6);
    check("timing_violations", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
